// File: rtl/fb_scanout_pkg.sv
// Shared video timing constants, bus widths and bank-swap state encoding for fb_scanout.
package fb_scanout_pkg;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 17;
  localparam int CNT_W    = 9;

  localparam int H_TOTAL  = 384;
  localparam int H_ACTIVE = 256;
  localparam int HS_START = 288;
  localparam int HS_END   = 319;
  localparam int V_TOTAL  = 264;
  localparam int V_ACTIVE = 224;
  localparam int VS_START = 240;
  localparam int VS_END   = 243;
  localparam int V_OFFSET = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PENDING,
    ST_SWAP
  } fb_state_e;
endpackage

// File: rtl/fb_scanout_if.sv
// Framebuffer memory bus: one write port and one read port with a one-clk read latency.
interface fb_scanout_if;
  import fb_scanout_pkg::*;

  logic              fb_we;
  logic [ADDR_W-1:0] fb_waddr;
  logic [DATA_W-1:0] fb_wdata;
  logic [ADDR_W-1:0] fb_raddr;
  logic [DATA_W-1:0] fb_rdata;

  modport master (output fb_we, fb_waddr, fb_wdata, fb_raddr, input fb_rdata);
  modport slave  (input fb_we, fb_waddr, fb_wdata, fb_raddr, output fb_rdata);
endinterface

// File: rtl/fb_video_timing.sv
// Horizontal/vertical pixel counters advanced by ce_pix; flags the step that enters vblank.
module fb_video_timing
  import fb_scanout_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ce_pix,
  output logic [CNT_W-1:0] hcnt,
  output logic [CNT_W-1:0] vcnt,
  output logic             vbl_start
);
  logic h_last;
  logic v_last;

  assign h_last    = (hcnt == CNT_W'(H_TOTAL - 1));
  assign v_last    = (vcnt == CNT_W'(V_TOTAL - 1));
  // True on the ce_pix step whose edge moves the counters to vcnt=V_ACTIVE, hcnt=0
  assign vbl_start = ce_pix && h_last && (vcnt == CNT_W'(V_ACTIVE - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (ce_pix) begin
      if (h_last) begin
        hcnt <= '0;
        vcnt <= v_last ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/fb_scanout.sv
// Framebuffer write gating, bank swap at vblank and display scan-out pipeline.
// Optional double buffering is enabled by defining FB_DOUBLE_BUF_EN.
module fb_scanout
  import fb_scanout_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce_pix,
  input  logic [7:0]  h,
  input  logic [7:0]  v,
  input  logic [2:0]  r,
  input  logic [2:0]  g,
  input  logic [1:0]  b,
  input  logic        done,
  input  logic        frame,
  fb_scanout_if.master fb,
  output logic [2:0]  vid_r,
  output logic [2:0]  vid_g,
  output logic [1:0]  vid_b,
  output logic        hsync,
  output logic        vsync,
  output logic        hblank,
  output logic        vblank,
  output logic        drop
);
  logic [CNT_W-1:0]  hcnt, vcnt;
  logic              vbl_start;
  logic              wr_bank, disp_bank, wr_open;
  logic              we_p1;
  logic [ADDR_W-1:0] waddr_p1;
  logic [DATA_W-1:0] wdata_p1;
  logic [7:0]        row_p0;
  logic [3:0]        sync_p0, sync_p1, sync_p2;
  logic              ce_d1;
  logic [DATA_W-1:0] rd_p1, vid_p2;

  fb_video_timing u_timing (
    .clk       (clk),
    .reset_n   (reset_n),
    .ce_pix    (ce_pix),
    .hcnt      (hcnt),
    .vcnt      (vcnt),
    .vbl_start (vbl_start)
  );

`ifdef FB_DOUBLE_BUF_EN
  fb_state_e state_q, state_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      wr_bank   <= 1'b0;
      disp_bank <= 1'b1;
    end else begin
      state_q <= state_d;
      if (state_q == ST_SWAP) begin
        disp_bank <= wr_bank;
        wr_bank   <= ~wr_bank;
      end
    end
  end

  // A frame landing on the vblank-start step goes straight to SWAP so it is not a frame late
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (frame) state_d = vbl_start ? ST_SWAP : ST_PENDING;
      ST_PENDING: if (vbl_start) state_d = ST_SWAP;
      ST_SWAP:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  assign wr_open = (state_q == ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) drop <= 1'b0;
    else          drop <= done & ~wr_open;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{frame, vbl_start};
  assign wr_bank    = 1'b0;
  assign disp_bank  = 1'b0;
  assign wr_open    = 1'b1;
  assign drop       = 1'b0;
`endif

  // Write stage p1: one clk after done is sampled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) we_p1 <= 1'b0;
    else          we_p1 <= done & wr_open;
  end

  always_ff @(posedge clk) begin
    if (done) begin
      waddr_p1 <= {wr_bank, v, h};
      wdata_p1 <= {r, g, b};
    end
  end

  assign fb.fb_we    = we_p1;
  assign fb.fb_waddr = waddr_p1;
  assign fb.fb_wdata = wdata_p1;

  // Read stage p0: address and timing flags from the live counters
  assign row_p0      = 8'(vcnt + CNT_W'(V_OFFSET));
  assign fb.fb_raddr = {disp_bank, row_p0, hcnt[7:0]};
  assign sync_p0     = {(hcnt >= CNT_W'(HS_START)) && (hcnt <= CNT_W'(HS_END)),
                        (vcnt >= CNT_W'(VS_START)) && (vcnt <= CNT_W'(VS_END)),
                        (hcnt >= CNT_W'(H_ACTIVE)),
                        (vcnt >= CNT_W'(V_ACTIVE))};

  // Stages p1/p2: read data for a pixel is valid the clk after its last ce_pix, so it is
  // either already held in rd_p1 or, with back-to-back ce_pix, still on fb_rdata.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ce_d1   <= 1'b0;
      rd_p1   <= '0;
      sync_p1 <= '0;
      sync_p2 <= '0;
      vid_p2  <= '0;
    end else begin
      ce_d1 <= ce_pix;
      if (ce_d1) rd_p1 <= fb.fb_rdata;
      if (ce_pix) begin
        sync_p1 <= sync_p0;
        sync_p2 <= sync_p1;
        vid_p2  <= (sync_p1[1] | sync_p1[0]) ? '0 : (ce_d1 ? fb.fb_rdata : rd_p1);
      end
    end
  end

  assign {hsync, vsync, hblank, vblank} = sync_p2;
  assign {vid_r, vid_g, vid_b}          = vid_p2;
endmodule

// File: tb/tb_fb_scanout.sv
// Scoreboard bench for fb_scanout: random renderer writes and pixel enables against a
// frame-level reference model; honours FB_DOUBLE_BUF_EN the same way as the design.
module tb_fb_scanout;
`ifdef FB_DOUBLE_BUF_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ce_pix = 1'b0;
  logic       done = 1'b0;
  logic       frame = 1'b0;
  logic [7:0] h = '0, v = '0;
  logic [2:0] r = '0, g = '0;
  logic [1:0] b = '0;
  logic [2:0] vid_r, vid_g;
  logic [1:0] vid_b;
  logic       hsync, vsync, hblank, vblank, drop;

  fb_scanout_if fbif ();

  fb_scanout dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ce_pix  (ce_pix),
    .h       (h),
    .v       (v),
    .r       (r),
    .g       (g),
    .b       (b),
    .done    (done),
    .frame   (frame),
    .fb      (fbif),
    .vid_r   (vid_r),
    .vid_g   (vid_g),
    .vid_b   (vid_b),
    .hsync   (hsync),
    .vsync   (vsync),
    .hblank  (hblank),
    .vblank  (vblank),
    .drop    (drop)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_fn(input logic [16:0] a);
    return (a[7:0] * 8'd3) ^ {a[14:8], a[15]} ^ (a[16] ? 8'h5A : 8'h00);
  endfunction

  // Synchronous framebuffer with one clk of read latency
  always @(posedge clk) fbif.fb_rdata <= mem_fn(fbif.fb_raddr);

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: pixel position, swap bookkeeping, expected-output queues
  int         hc = 0, vc = 0;
  bit         pend = 1'b0, swp = 1'b0, wrb = 1'b0, dspb = DBL;
  logic [26:0] wq[$];
  logic [11:0] pq[$];

  function automatic logic [11:0] pix_exp(input int px, input int ln, input bit bank);
    bit hb, vb, hs, vs;
    logic [7:0] d;
    hb = (px >= 256);
    vb = (ln >= 224);
    hs = (px >= 288) && (px <= 319);
    vs = (ln >= 240) && (ln <= 243);
    d  = (hb || vb) ? 8'h00 : mem_fn({bank, 8'(ln + 16), 8'(px)});
    return {d, hs, vs, hb, vb};
  endfunction

  initial begin
    bit open, vbs;
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        hc = 0; vc = 0; pend = 1'b0; swp = 1'b0; wrb = 1'b0; dspb = DBL;
        wq.delete();
        pq.delete();
      end else begin
        open = !(pend || swp);
        vbs  = ce_pix && (hc == 383) && (vc == 223);
        if (done)
          wq.push_back(open ? {1'b1, 1'b0, wrb, v, h, r, g, b} : {1'b0, 1'b1, 17'h0, 8'h0});
        if (ce_pix) begin
          pq.push_back(pix_exp(hc, vc, dspb));
          hc++;
          if (hc == 384) begin
            hc = 0;
            vc = (vc == 263) ? 0 : vc + 1;
          end
        end
        if (DBL) begin
          if (swp) begin
            dspb = wrb;
            wrb  = !wrb;
            swp  = 1'b0;
          end else if (pend) begin
            if (vbs) begin pend = 1'b0; swp = 1'b1; end
          end else if (frame) begin
            if (vbs) swp = 1'b1;
            else     pend = 1'b1;
          end
        end
      end
    end
  end

  // Monitor: compares whatever the DUT presents against the queued expectations
  initial begin
    logic [26:0] wact, wexp;
    logic [11:0] pexp;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (fbif.fb_we || drop || wq.size() != 0) begin
          wact = {fbif.fb_we, drop, fbif.fb_we ? fbif.fb_waddr : 17'h0,
                  fbif.fb_we ? fbif.fb_wdata : 8'h0};
          wexp = (wq.size() != 0) ? wq.pop_front() : 27'h0;
          check("write", 32'(wact), 32'(wexp));
        end
        if (pq.size() >= 2) begin
          pexp = pq.pop_front();
          check("pixel", 32'({vid_r, vid_g, vid_b, hsync, vsync, hblank, vblank}), 32'(pexp));
        end
        if (hc < 256 && vc < 224)
          check("raddr", 32'(fbif.fb_raddr), 32'({dspb, 8'(vc + 16), 8'(hc)}));
      end
    end
  end

  task automatic apply_reset(input int cycles);
    reset_n = 1'b0;
    done    = 1'b0;
    frame   = 1'b0;
    ce_pix  = 1'b0;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    check("rst_we", 32'(fbif.fb_we), 32'(0));
    check("rst_drop", 32'(drop), 32'(0));
    check("rst_vid", 32'({vid_r, vid_g, vid_b}), 32'(0));
    check("rst_sync", 32'({hsync, vsync, hblank, vblank}), 32'(0));
    check("rst_raddr", 32'(fbif.fb_raddr), 32'({DBL, 8'd16, 8'd0}));
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic rand_pixel(input int done_pct);
    done = ($urandom_range(0, 99) < done_pct);
    h    = 8'($urandom);
    v    = 8'($urandom);
    {r, g, b} = 8'($urandom);
  endtask

  initial begin
    bit fr_sent;
    fr_sent = 1'b0;
    apply_reset(3);

    // First write after reset lands in bank 0 at {0, 0x34, 0x12}
    done = 1'b1; h = 8'h12; v = 8'h34; {r, g, b} = 8'hA5;
    @(posedge clk); #1;
    done = 1'b0;
    @(negedge clk);
    check("first_waddr", 32'(fbif.fb_waddr), 32'(17'h03412));
    @(posedge clk); #1;

    // Phase A: sparse ce_pix, a frame pulse, then a reset while the swap is still pending
    for (int i = 0; i < 1500; i++) begin
      rand_pixel(40);
      ce_pix = ($urandom_range(0, 1) == 1);
      frame  = (i == 700);
      if (i == 1200) begin
        apply_reset(2);
      end else begin
        @(posedge clk); #1;
      end
    end

    // Phase B: full-rate ce_pix through to vblank; frame with a write at line 100,
    // a second frame while pending at line 150, then the swap at vblank start
    ce_pix = 1'b1;
    for (int n = 0; n < 95000 && vc < 226; n++) begin
      rand_pixel(30);
      frame = 1'b0;
      if (!fr_sent && vc == 100) begin
        frame = 1'b1;
        done  = 1'b1;
        fr_sent = 1'b1;
      end else if (vc == 150 && hc == 0) begin
        frame = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (vc < 226) check("phaseB_bound", 32'(vc), 32'(226));

    done = 1'b1; h = 8'h01; v = 8'h02; frame = 1'b0;
    @(posedge clk); #1;
    done = 1'b0;
    @(negedge clk);
    check("swap_disp_bank", 32'(fbif.fb_raddr[16]), 32'(0));
    check("swap_wr_bank", 32'(fbif.fb_waddr[16]), 32'(DBL));
    repeat (4) @(posedge clk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
